// File: rtl/obstacle_control.sv
// obstacle_control: bouncing-block FSM driving a draw/erase/probe/move datapath
//   clk, reset (async, active-high); start launches a run from IDLE
//   xdir/ydir/timer_done/obstacle come from the datapath; en_*/s_*/plot drive it
//   bounce_count counts direction reversals since INIT and saturates at all-ones
//   OBSTACLE_CONTROL_PAUSE_EN adds a pause input that freezes the WAIT state
module obstacle_control #(
  parameter int BOUNCE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                xdir,
  input  logic                ydir,
  input  logic                timer_done,
  input  logic                obstacle,
`ifdef OBSTACLE_CONTROL_PAUSE_EN
  input  logic                pause,
`endif
  output logic                en_xpos,
  output logic                en_ypos,
  output logic                en_xdir,
  output logic                en_ydir,
  output logic                en_timer,
  output logic [1:0]          s_xpos,
  output logic [1:0]          s_ypos,
  output logic                s_xdir,
  output logic                s_ydir,
  output logic                s_timer,
  output logic                s_color,
  output logic [1:0]          s_obs_xy,
  output logic                plot,
  output logic [BOUNCE_W-1:0] bounce_count
);
  typedef enum logic [3:0] {IDLE, INIT, DRAW, WAIT, ERASE, PX, EX, PY, EY, MOVE} state_t;
  state_t state, next;
  logic hold;
`ifdef OBSTACLE_CONTROL_PAUSE_EN
  assign hold = (state == WAIT) && pause;
`else
  assign hold = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bounce_count <= '0;
    end else begin
      state <= next;
      if (state == INIT) bounce_count <= '0;
      else if ((en_xdir || en_ydir) && !(&bounce_count)) bounce_count <= bounce_count + BOUNCE_W'(1);
    end
  always_comb begin
    next = state;
    {en_xpos, en_ypos, en_xdir, en_ydir, en_timer} = '0;
    {s_xpos, s_ypos, s_obs_xy} = '0;
    {s_xdir, s_ydir, s_timer, s_color, plot} = '0;
    case (state)
      IDLE: next = start ? INIT : IDLE;
      INIT: begin
        {en_xpos, en_ypos, en_xdir, en_ydir, en_timer} = '1;
        next = DRAW;
      end
      DRAW: begin
        plot = 1'b1;
        s_color = 1'b1;
        next = WAIT;
      end
      WAIT:
        if (!hold) begin
          en_timer = 1'b1;
          s_timer = !timer_done;
          next = timer_done ? ERASE : WAIT;
        end
      ERASE: begin
        plot = 1'b1;
        next = PX;
      end
      PX: begin
        s_obs_xy = {1'b1, xdir};
        next = EX;
      end
      EX: begin
        s_obs_xy = {1'b1, xdir};
        en_xdir = obstacle;
        s_xdir = obstacle;
        next = PY;
      end
      PY: begin
        s_obs_xy = {1'b0, ydir};
        next = EY;
      end
      EY: begin
        s_obs_xy = {1'b0, ydir};
        en_ydir = obstacle;
        s_ydir = obstacle;
        next = MOVE;
      end
      MOVE: begin
        en_xpos = 1'b1;
        en_ypos = 1'b1;
        s_xpos = {xdir, !xdir};
        s_ypos = {ydir, !ydir};
        next = DRAW;
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_obstacle_control.sv
// tb_obstacle_control: randomized frame-level checking of obstacle_control
module tb_obstacle_control;
  localparam int P_INIT = 1, P_DRAW = 2, P_WAIT = 3, P_ERASE = 4, P_PX = 5;
  localparam int P_EX = 6, P_PY = 7, P_EY = 8, P_MOVE = 9, P_PAUSE = 10;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic xdir = 1'b0, ydir = 1'b0, timer_done = 1'b0, obstacle = 1'b0;
`ifdef OBSTACLE_CONTROL_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic en_xpos, en_ypos, en_xdir, en_ydir, en_timer;
  logic [1:0] s_xpos, s_ypos, s_obs_xy;
  logic s_xdir, s_ydir, s_timer, s_color, plot;
  logic [7:0] bounce_count;
  logic [15:0] outs, exp;
  int vectors = 0, miss = 0, bcnt = 0;
  assign outs = {en_xpos, en_ypos, en_xdir, en_ydir, en_timer, s_xpos, s_ypos,
                 s_xdir, s_ydir, s_timer, s_color, s_obs_xy, plot};
  obstacle_control dut (
    .clk(clk), .reset(reset), .start(start), .xdir(xdir), .ydir(ydir),
    .timer_done(timer_done), .obstacle(obstacle),
`ifdef OBSTACLE_CONTROL_PAUSE_EN
    .pause(pause),
`endif
    .en_xpos(en_xpos), .en_ypos(en_ypos), .en_xdir(en_xdir), .en_ydir(en_ydir),
    .en_timer(en_timer), .s_xpos(s_xpos), .s_ypos(s_ypos), .s_xdir(s_xdir),
    .s_ydir(s_ydir), .s_timer(s_timer), .s_color(s_color), .s_obs_xy(s_obs_xy),
    .plot(plot), .bounce_count(bounce_count)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] golden(int p, logic xd, logic yd, logic ob, logic td);
    logic [4:0] en;
    logic [1:0] sx, sy, so;
    logic sxd, syd, st, sc, pl;
    {en, sx, sy, so, sxd, syd, st, sc, pl} = '0;
    case (p)
      P_INIT: en = 5'b11111;
      P_DRAW: begin pl = 1'b1; sc = 1'b1; end
      P_WAIT: begin en[0] = 1'b1; st = !td; end
      P_ERASE: pl = 1'b1;
      P_PX: so = xd ? 2'd3 : 2'd2;
      P_EX: begin so = xd ? 2'd3 : 2'd2; en[2] = ob; sxd = ob; end
      P_PY: so = yd ? 2'd1 : 2'd0;
      P_EY: begin so = yd ? 2'd1 : 2'd0; en[1] = ob; syd = ob; end
      P_MOVE: begin en[4:3] = 2'b11; sx = xd ? 2'd2 : 2'd1; sy = yd ? 2'd2 : 2'd1; end
      default: ;
    endcase
    return {en, sx, sy, sxd, syd, st, sc, so, pl};
  endfunction
  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      {xdir, ydir, timer_done, obstacle} = 4'($urandom);
      #1;
      vectors++;
      if ({outs, bounce_count} !== 24'h0) begin
        miss++;
        $display("FAIL idle[%0d]: outs=%h bounce=%0d, want 0/0", i, outs, bounce_count);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset;
    {xdir, ydir, timer_done, obstacle} = 4'($urandom);
    start = 1'b1;
    #1;
    vectors++;
    if ({outs, bounce_count} !== 24'h0) begin
      miss++;
      $display("FAIL reset_held: outs=%h bounce=%0d, want 0/0", outs, bounce_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(3);
  endtask
  task automatic test_start;
    start = 1'b1;
    {xdir, ydir, timer_done, obstacle} = 4'($urandom);
    #1;
    vectors++;
    if (outs !== 16'h0) begin
      miss++;
      $display("FAIL start_idle: outs=%h want 0", outs);
    end
    @(posedge clk); #1;
    start = 1'($urandom);
    {xdir, ydir, timer_done, obstacle} = 4'($urandom);
    #1;
    exp = golden(P_INIT, xdir, ydir, obstacle, timer_done);
    vectors++;
    if (outs !== exp) begin
      miss++;
      $display("FAIL init: outs=%h want %h", outs, exp);
    end
    @(posedge clk); #1;
    bcnt = 0;
    {xdir, ydir} = 2'($urandom);
  endtask
  // Walks one frame from DRAW: np paused cycles, nw WAIT cycles (last has
  // timer_done), then ERASE..MOVE; the bench flips its own direction bits as
  // the datapath would when a reversal is commanded.
  task automatic run_frame(int nw, bit ox, bit oy, bit rst_ey, int np);
    int ph[$];
    bit td;
    ph = {P_DRAW};
    repeat (np) ph.push_back(P_PAUSE);
    repeat (nw) ph.push_back(P_WAIT);
    ph = {ph, P_ERASE, P_PX, P_EX, P_PY, P_EY, P_MOVE};
    for (int i = 0; i < ph.size(); i++) begin
      start = 1'($urandom);
      td = (ph[i] == P_WAIT) ? (i == np + nw) : 1'($urandom);
      timer_done = td;
      obstacle = (ph[i] == P_EX) ? ox : (ph[i] == P_EY) ? oy : 1'($urandom);
`ifdef OBSTACLE_CONTROL_PAUSE_EN
      pause = (ph[i] == P_PAUSE) ? 1'b1 : (ph[i] == P_WAIT) ? 1'b0 : 1'($urandom);
`endif
      #1;
      if (rst_ey && ph[i] == P_EY) begin
        reset = 1'b1;
        #1;
        vectors++;
        if ({outs, bounce_count} !== 24'h0) begin
          miss++;
          $display("FAIL reset_in_ey: outs=%h bounce=%0d, want 0/0", outs, bounce_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bcnt = 0;
        return;
      end
      exp = golden(ph[i], xdir, ydir, obstacle, td);
      vectors++;
      if (outs !== exp || (ph[i] == P_MOVE && bounce_count !== 8'(bcnt))) begin
        miss++;
        $display("FAIL frame step %0d phase %0d: outs=%h bounce=%0d, want %h/%0d",
                 i, ph[i], outs, bounce_count, exp, bcnt);
      end
      @(posedge clk); #1;
      if ((ph[i] == P_EX && ox) || (ph[i] == P_EY && oy)) bcnt = (bcnt + 1 > 255) ? 255 : bcnt + 1;
      if (ph[i] == P_EX && ox) xdir = !xdir;
      if (ph[i] == P_EY && oy) ydir = !ydir;
    end
  endtask
  task automatic test_directed_frame;
    xdir = 1'b1;
    ydir = 1'b0;
    run_frame(3, 1'b1, 1'b0, 1'b0, 0);
    vectors++;
    if (bounce_count !== 8'd1) begin
      miss++;
      $display("FAIL directed_bounce: bounce=%0d want 1", bounce_count);
    end
  endtask
  task automatic test_random_frames;
    for (int f = 0; f < 30; f++)
      run_frame(int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom), 1'b0, 0);
  endtask
  task automatic test_saturation;
    for (int f = 0; f < 300; f++) run_frame(1, 1'b1, 1'b1, 1'b0, 0);
    vectors++;
    if (bounce_count !== 8'd255) begin
      miss++;
      $display("FAIL saturation: bounce=%0d want 255", bounce_count);
    end
  endtask
  task automatic test_reset_mid;
    run_frame(2, 1'b1, 1'b1, 1'b1, 0);
    idle_cycles(4);
    test_start;
    run_frame(2, 1'b0, 1'b1, 1'b0, 0);
  endtask
`ifdef OBSTACLE_CONTROL_PAUSE_EN
  task automatic test_pause;
    run_frame(3, 1'($urandom), 1'($urandom), 1'b0, 5);
  endtask
`endif
  initial begin
    test_reset;
    test_start;
    test_directed_frame;
    test_random_frames;
    test_saturation;
    test_reset_mid;
`ifdef OBSTACLE_CONTROL_PAUSE_EN
    test_pause;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
